hvac_mode_sequencer: RTL and testbench

Parametrised operating-mode sequencer for the home-automation climate controllers. It conditions two raw push-buttons (next/previous) with synchronisation and debounce, then steps a mode register through `NUM_MODES` modes with optional wrap-around. It adds a lock input and a long-press "force OFF" gesture. It sits between the front-panel button pins and the AC/heater control logic, which consumes `current_mode` and the `mode_changed` strobe.

---
 rtl/hvac_pkg.sv | 19 +
 rtl/hvac_mode_sequencer_button_conditioner.sv | 81 ++++++++
 rtl/hvac_mode_sequencer.sv | 91 +++++++++
 tb/tb_hvac_mode_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hvac_pkg.sv
// Shared constants and helpers for the climate-controller mode sequencer.
package hvac_pkg;

  typedef enum logic [1:0] {
    MODE_OFF       = 2'd0,
    MODE_AUTOMATIC = 2'd1,
    MODE_FAST_COOL = 2'd2,
    MODE_ECO       = 2'd3
  } hvac_mode_e;

  function automatic int clog2_min1(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/hvac_mode_sequencer_button_conditioner.sv
// Synchronises, debounces and edge-detects one raw button; also times long holds.
module button_conditioner
  import hvac_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press,
  output logic held
);

  localparam int CNT_W = clog2_min1(DEBOUNCE_CYCLES + 1);
  localparam int TMR_W = clog2_min1(HOLD_CYCLES + 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             level_dly_q;
  logic             press_q, press_d;
  logic             held_q, held_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = ~level_q;
        cnt_d   = CNT_W'(0);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = CNT_W'(0);
    end

    // Hold timer saturates so the held pulse cannot repeat until release.
    if (!level_q) begin
      tmr_d = TMR_W'(0);
    end else if (tmr_q != TMR_W'(HOLD_CYCLES)) begin
      tmr_d = tmr_q + TMR_W'(1);
    end else begin
      tmr_d = tmr_q;
    end

    press_d = level_q & ~level_dly_q;
    // Registered one edge early so the pulse lands HOLD_CYCLES edges after the rise.
    held_d  = level_q && (tmr_q == TMR_W'(HOLD_CYCLES - 2));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
      held_q      <= 1'b0;
      cnt_q       <= CNT_W'(0);
      tmr_q       <= TMR_W'(0);
    end else begin
      sync1_q     <= btn;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      press_q     <= press_d;
      held_q      <= held_d;
      cnt_q       <= cnt_d;
      tmr_q       <= tmr_d;
    end
  end

  assign level = level_q;
  assign press = press_q;
  assign held  = held_q;

endmodule

// File: rtl/hvac_mode_sequencer.sv
// Steps the climate operating mode from debounced next/prev buttons, with lock and long-press force-OFF.
module hvac_mode_sequencer
  import hvac_pkg::*;
#(
  parameter int  NUM_MODES         = 4,
  parameter int  DEBOUNCE_CYCLES   = 16,
  parameter int  LONG_PRESS_CYCLES = 1000,
  parameter int  RESET_MODE        = 0,
  parameter int  WRAP              = 1,
  localparam int MODE_W            = clog2_min1(NUM_MODES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_next,
  input  logic              btn_prev,
  input  logic              lock,
  output logic [MODE_W-1:0] current_mode,
  output logic              mode_changed,
  output logic              long_press
);

  localparam logic [MODE_W-1:0] MODE_MAX = MODE_W'(NUM_MODES - 1);
  localparam logic [MODE_W-1:0] MODE_MIN = MODE_W'(MODE_OFF);

  logic              next_press, prev_press, next_held;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic              mode_changed_q, long_press_q;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES    (LONG_PRESS_CYCLES)
  ) u_next (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_next),
    .level(),
    .press(next_press),
    .held (next_held)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES    (LONG_PRESS_CYCLES)
  ) u_prev (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_prev),
    .level(),
    .press(prev_press),
    .held ()
  );

  // Force-OFF overrides lock and any step; simultaneous next+prev cancel out.
  always_comb begin
    mode_d = mode_q;
    if (next_held) begin
      mode_d = MODE_MIN;
    end else if (!lock && next_press && !prev_press) begin
      if (mode_q == MODE_MAX) begin
        mode_d = (WRAP != 0) ? MODE_MIN : mode_q;
      end else begin
        mode_d = mode_q + MODE_W'(1);
      end
    end else if (!lock && prev_press && !next_press) begin
      if (mode_q == MODE_MIN) begin
        mode_d = (WRAP != 0) ? MODE_MAX : mode_q;
      end else begin
        mode_d = mode_q - MODE_W'(1);
      end
    end else begin
      mode_d = mode_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q         <= MODE_W'(RESET_MODE);
      mode_changed_q <= 1'b0;
      long_press_q   <= 1'b0;
    end else begin
      mode_q         <= mode_d;
      mode_changed_q <= (mode_d != mode_q);
      long_press_q   <= next_held;
    end
  end

  assign current_mode = mode_q;
  assign mode_changed = mode_changed_q;
  assign long_press   = long_press_q;

endmodule

// File: tb/tb_hvac_mode_sequencer.sv
// Bench for hvac_mode_sequencer: event-scheduling model checked every cycle plus literal expectations.
module tb_hvac_mode_sequencer;

  localparam int DEB = 16;
  localparam int LP  = 1000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic bn0 = 1'b0, bp0 = 1'b0, lk0 = 1'b0;
  logic bn1 = 1'b0, bp1 = 1'b0, lk1 = 1'b0;
  logic [1:0] mode0;
  logic [2:0] mode1;
  logic mc0, lp0, mc1, lp1;

  always #5 clk = ~clk;

  hvac_mode_sequencer dut0 (
    .clk(clk), .rst(rst), .btn_next(bn0), .btn_prev(bp0), .lock(lk0),
    .current_mode(mode0), .mode_changed(mc0), .long_press(lp0)
  );

  hvac_mode_sequencer #(.NUM_MODES(6), .WRAP(0)) dut1 (
    .clk(clk), .rst(rst), .btn_next(bn1), .btn_prev(bp1), .lock(lk1),
    .current_mode(mode1), .mode_changed(mc1), .long_press(lp1)
  );

  // kind: 1 = next step, 2 = prev step, 3 = force OFF
  typedef struct {int dut; int cyc; int kind;} ev_t;
  ev_t evq[$];

  int cyc = 0;
  int checks = 0, errors = 0;
  int exp_mode[2] = '{0, 0};
  int exp_mc[2]   = '{0, 0};
  int exp_lp[2]   = '{0, 0};
  int nm[2]       = '{4, 6};
  int wr[2]       = '{1, 0};
  int mc_cnt[2]   = '{0, 0};
  int lp_cnt[2]   = '{0, 0};
  int last_mc[2]  = '{0, 0};
  int last_lp[2]  = '{0, 0};

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic int step_mode(input int m, input int n, input int w, input int up);
    if (up != 0) return (m == n - 1) ? ((w != 0) ? 0 : m) : m + 1;
    else         return (m == 0) ? ((w != 0) ? n - 1 : 0) : m - 1;
  endfunction

  // Model: apply the events scheduled for this edge.
  initial forever begin
    @(posedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        exp_mode[d] = 0; exp_mc[d] = 0; exp_lp[d] = 0;
      end else begin
        int nn, np, off, old, lkv;
        nn = 0; np = 0; off = 0;
        foreach (evq[i]) begin
          if (evq[i].dut == d && evq[i].cyc == cyc) begin
            if (evq[i].kind == 1) nn++;
            else if (evq[i].kind == 2) np++;
            else off = 1;
          end
        end
        lkv = (d == 0) ? int'(lk0) : int'(lk1);
        old = exp_mode[d];
        if (off != 0) exp_mode[d] = 0;
        else if (lkv == 0 && nn > 0 && np == 0) exp_mode[d] = step_mode(old, nm[d], wr[d], 1);
        else if (lkv == 0 && np > 0 && nn == 0) exp_mode[d] = step_mode(old, nm[d], wr[d], 0);
        exp_mc[d] = (exp_mode[d] != old) ? 1 : 0;
        exp_lp[d] = off;
      end
    end
    for (int i = evq.size() - 1; i >= 0; i--) begin
      if (evq[i].cyc <= cyc) evq.delete(i);
    end
  end

  // Compare every cycle and keep pulse statistics.
  initial forever begin
    @(negedge clk);
    check("mode0", int'(mode0), exp_mode[0]);
    check("mc0",   int'(mc0),   exp_mc[0]);
    check("lp0",   int'(lp0),   exp_lp[0]);
    check("mode1", int'(mode1), exp_mode[1]);
    check("mc1",   int'(mc1),   exp_mc[1]);
    check("lp1",   int'(lp1),   exp_lp[1]);
    if (mc0) begin mc_cnt[0]++; last_mc[0] = cyc; end
    if (lp0) begin lp_cnt[0]++; last_lp[0] = cyc; end
    if (mc1) begin mc_cnt[1]++; last_mc[1] = cyc; end
    if (lp1) begin lp_cnt[1]++; last_lp[1] = cyc; end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic set_btn(input int d, input int which, input logic v);
    if (d == 0) begin
      if (which == 1) bn0 = v; else bp0 = v;
    end else begin
      if (which == 1) bn1 = v; else bp1 = v;
    end
  endtask

  // Raw level first sampled at edge e0 and held for w edges.
  task automatic sched(input int d, input int which, input int e0, input int w);
    if (w >= DEB) evq.push_back('{d, e0 + DEB + 3, which});
    if (which == 1 && w >= LP) evq.push_back('{d, e0 + DEB + 1 + LP, 3});
  endtask

  task automatic press(input int d, input int which, input int w, output int e0);
    @(negedge clk);
    set_btn(d, which, 1'b1);
    e0 = cyc + 1;
    sched(d, which, e0, w);
    repeat (w) @(negedge clk);
    set_btn(d, which, 1'b0);
    repeat (DEB + 8) @(negedge clk);
  endtask

  task automatic press_both(input int d, input int w);
    int e0;
    @(negedge clk);
    set_btn(d, 1, 1'b1);
    set_btn(d, 2, 1'b1);
    e0 = cyc + 1;
    sched(d, 1, e0, w);
    sched(d, 2, e0, w);
    repeat (w) @(negedge clk);
    set_btn(d, 1, 1'b0);
    set_btn(d, 2, 1'b0);
    repeat (DEB + 8) @(negedge clk);
  endtask

  task automatic assert_reset();
    #2;
    rst = 1'b0;
    evq.delete();
    for (int d = 0; d < 2; d++) begin
      exp_mode[d] = 0; exp_mc[d] = 0; exp_lp[d] = 0;
    end
    #1;
    check("rst_mode0", int'(mode0), 0);
    check("rst_mc0",   int'(mc0),   0);
    check("rst_lp0",   int'(lp0),   0);
    check("rst_mode1", int'(mode1), 0);
  endtask

  initial begin
    int e0, base_mc, base_lp;
    int seq[5] = '{1, 2, 3, 0, 1};

    #1;
    check("reset_mode0", int'(mode0), 0);
    check("reset_mc0",   int'(mc0),   0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Five clean next presses with wrap.
    for (int i = 0; i < 5; i++) begin
      press(0, 1, 20, e0);
      check("next_seq", int'(mode0), seq[i]);
      check("press_latency", last_mc[0] - e0, 19);
    end
    check("next_pulses", mc_cnt[0], 5);

    // Glitch shorter than the debounce window, then a minimum-length press.
    base_mc = mc_cnt[0];
    press(0, 1, 10, e0);
    check("glitch_mode", int'(mode0), 1);
    check("glitch_pulses", mc_cnt[0] - base_mc, 0);
    press(0, 1, 16, e0);
    check("min_press_mode", int'(mode0), 2);

    // Long press from mode 2: step to 3, then force OFF.
    base_mc = mc_cnt[0];
    base_lp = lp_cnt[0];
    press(0, 1, LP + 500, e0);
    check("long_mode", int'(mode0), 0);
    check("long_pulses", lp_cnt[0] - base_lp, 1);
    check("long_latency", last_lp[0] - e0, 1017);
    check("long_mc_pulses", mc_cnt[0] - base_mc, 2);

    // Lock behaviour.
    lk0 = 1'b1;
    press(0, 1, 20, e0);
    press(0, 2, 20, e0);
    check("locked_mode", int'(mode0), 0);
    lk0 = 1'b0;
    press(0, 1, 20, e0);
    press(0, 1, 20, e0);
    check("unlocked_mode", int'(mode0), 2);
    lk0 = 1'b1;
    base_lp = lp_cnt[0];
    press(0, 1, LP + 100, e0);
    check("locked_long_mode", int'(mode0), 0);
    check("locked_long_pulse", lp_cnt[0] - base_lp, 1);
    lk0 = 1'b0;
    base_mc = mc_cnt[0];
    press_both(0, 20);
    check("both_mode", int'(mode0), 0);
    check("both_pulses", mc_cnt[0] - base_mc, 0);
    press(0, 2, 20, e0);
    check("prev_wrap", int'(mode0), 3);

    // Saturating build with six modes.
    base_mc = mc_cnt[1];
    for (int i = 0; i < 7; i++) press(1, 1, 20, e0);
    check("sat_top", int'(mode1), 5);
    check("sat_top_pulses", mc_cnt[1] - base_mc, 5);
    for (int i = 0; i < 5; i++) press(1, 2, 20, e0);
    check("sat_down", int'(mode1), 0);
    base_mc = mc_cnt[1];
    press(1, 2, 20, e0);
    check("sat_bottom", int'(mode1), 0);
    check("sat_bottom_pulses", mc_cnt[1] - base_mc, 0);

    // Reset mid-debounce with the button held through release.
    @(negedge clk);
    bn0 = 1'b1;
    repeat (8) @(negedge clk);
    assert_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    e0 = cyc + 1;
    sched(0, 1, e0, 40);
    base_mc = mc_cnt[0];
    repeat (40) @(negedge clk);
    bn0 = 1'b0;
    repeat (DEB + 8) @(negedge clk);
    check("held_reset_mode", int'(mode0), 1);
    check("held_reset_pulses", mc_cnt[0] - base_mc, 1);

    // Reset mid-long-press with the button held through release.
    @(negedge clk);
    bn0 = 1'b1;
    e0 = cyc + 1;
    sched(0, 1, e0, DEB);
    repeat (300) @(negedge clk);
    check("pre_reset_mode", int'(mode0), 2);
    assert_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    e0 = cyc + 1;
    sched(0, 1, e0, 30);
    base_mc = mc_cnt[0];
    base_lp = lp_cnt[0];
    repeat (30) @(negedge clk);
    bn0 = 1'b0;
    repeat (DEB + 8) @(negedge clk);
    check("long_reset_mode", int'(mode0), 1);
    check("long_reset_step", mc_cnt[0] - base_mc, 1);
    check("long_reset_nolp", lp_cnt[0] - base_lp, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
